// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronised RX, mid-bit sampling, optional parity,
// framing/parity/overrun status, valid/ready word output.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   RX          asynchronous serial input, idle high
//   data_out    received word, held while UART_Valid
//   UART_Valid  word and status flags are presented
//   UART_Ready  consumer accepts on UART_Valid & UART_Ready
//   UART_Busy   a frame is being received
//   UART_Error  stop bit of the held frame was 0
//   parity_err  parity mismatch on the held frame
//   overrun     sticky: a completed frame was dropped
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 UART_Valid,
  input  logic                 UART_Ready,
  output logic                 UART_Busy,
  output logic                 UART_Error,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_d;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_perr;
  logic                 done;
  logic                 done_ferr;
  logic                 half_tick;
  logic                 full_tick;
  logic                 accept;

  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);
  assign accept    = UART_Valid & UART_Ready;
  assign UART_Busy = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (rx_d && !rx_s) state_n = START;
      START:
        if (half_tick) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (full_tick && bit_cnt == LAST_BIT)
          state_n = PARITY_EN ? PARITY : STOP;
      PARITY:
        if (full_tick) state_n = STOP;
      STOP:
        if (full_tick) state_n = rx_s ? IDLE : BREAK;
      BREAK:
        if (rx_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frame_perr <= 1'b0;
      done       <= 1'b0;
      done_ferr  <= 1'b0;
      data_out   <= '0;
      UART_Valid <= 1'b0;
      UART_Error <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      state   <= state_n;

      // Restart the baud count on every state change so the first
      // START interval is a half bit and all later ones are mid-bit.
      if (state_n != state || full_tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == START) begin
        bit_cnt    <= '0;
        frame_perr <= 1'b0;
      end

      if (state == DATA && full_tick) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == PARITY && full_tick)
        frame_perr <= rx_s ^ (^shift) ^ PARITY_ODD;

      done <= (state == STOP) && full_tick;
      if (state == STOP && full_tick)
        done_ferr <= !rx_s;

      // A new frame wins over a same-cycle handshake; otherwise a
      // frame arriving on top of an unaccepted word is dropped.
      if (done) begin
        if (!UART_Valid || UART_Ready) begin
          data_out   <= shift;
          UART_Error <= done_ferr;
          parity_err <= frame_perr;
          UART_Valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        UART_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: an 8N1 and an 8E1 instance driven with
// directed and random frames, scoreboarded against frame-level expectations.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx   [2];
  logic       rdy  [2];
  logic [7:0] dout [2];
  logic       vld  [2];
  logic       busy [2];
  logic       ferr [2];
  logic       perr [2];
  logic       ovr  [2];

  exp_t q0[$];
  exp_t q1[$];
  logic exp_ovr [2];
  int   n_vec;
  int   n_err;

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .PARITY_EN(1'b0),
    .PARITY_ODD(1'b0)
  ) u_n (
    .clk(clk),
    .rst(rst),
    .RX(rx[0]),
    .data_out(dout[0]),
    .UART_Valid(vld[0]),
    .UART_Ready(rdy[0]),
    .UART_Busy(busy[0]),
    .UART_Error(ferr[0]),
    .parity_err(perr[0]),
    .overrun(ovr[0])
  );

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0)
  ) u_e (
    .clk(clk),
    .rst(rst),
    .RX(rx[1]),
    .data_out(dout[1]),
    .UART_Valid(vld[1]),
    .UART_Ready(rdy[1]),
    .UART_Busy(busy[1]),
    .UART_Error(ferr[1]),
    .parity_err(perr[1]),
    .overrun(ovr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  // Frame-level model: parity is checked against the even-parity rule
  // for the parity instance; a frame finishing while an earlier word
  // is still unaccepted (Ready low) is lost and raises overrun.
  task automatic send_frame(input int k, input logic [7:0] d,
                            input logic par, input logic stop);
    exp_t e;
    e.d  = d;
    e.fe = !stop;
    e.pe = (k == 1) ? (par != (^d)) : 1'b0;
    if (!rdy[k] && qsize(k) != 0)
      exp_ovr[k] = 1'b1;
    else if (k == 0)
      q0.push_back(e);
    else
      q1.push_back(e);
    rx[k] = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx[k] = d[i];
      wait_bits(1);
    end
    if (k == 1) begin
      rx[k] = par;
      wait_bits(1);
    end
    rx[k] = stop;
    wait_bits(1);
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 64 && qsize(k) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("drain%0d pending", k), qsize(k), 0);
    if (k == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    n_vec++;
    if (qsize(k) == 0) begin
      n_err++;
      $display("FAIL unexpected%0d: got data=%h fe=%b pe=%b, expected none",
               k, dout[k], ferr[k], perr[k]);
    end else begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      if (dout[k] !== e.d || ferr[k] !== e.fe || perr[k] !== e.pe) begin
        n_err++;
        $display("FAIL frame%0d: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                 k, dout[k], ferr[k], perr[k], e.d, e.fe, e.pe);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < 2; k++)
        if (vld[k] && rdy[k]) pop_check(k);
    end
  end

  initial begin
    logic [7:0] d;
    logic       stp;
    logic       par;
    int         gap;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rx[k]      = 1'b1;
      rdy[k]     = 1'b1;
      exp_ovr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d outputs", k),
          {dout[k], vld[k], busy[k], ferr[k], perr[k], ovr[k]}, 0);
    end
    rst = 1'b1;
    wait_bits(1);

    send_frame(0, 8'hA5, 1'b0, 1'b1);
    drain(0);
    wait_bits(1);

    rx[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("false start busy", busy[0], 1);
    @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("false start idle", busy[0], 0);
    chk("false start valid", vld[0], 0);

    send_frame(0, 8'h5A, 1'b0, 1'b0);
    wait_bits(40);
    chk("break busy", busy[0], 1);
    drain(0);
    rx[0] = 1'b1;
    wait_bits(1);
    chk("break release", busy[0], 0);

    send_frame(1, 8'h07, 1'b1, 1'b1);
    drain(1);
    send_frame(1, 8'h07, 1'b0, 1'b1);
    drain(1);

    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 2; k++) begin
        d   = 8'($urandom);
        stp = ($urandom_range(0, 9) != 0);
        par = (^d) ^ ($urandom_range(0, 3) == 0);
        send_frame(k, d, par, stp);
        gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
        if (gap > 0) begin
          rx[k] = 1'b1;
          wait_bits(gap);
        end
        drain(k);
      end
    end
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    wait_bits(1);
    chk("overrun0 quiet", ovr[0], exp_ovr[0]);
    chk("overrun1 quiet", ovr[1], exp_ovr[1]);

    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    wait_bits(1);
    chk("overrun held data", dout[0], 8'h11);
    chk("overrun held valid", vld[0], 1);
    chk("overrun flag", ovr[0], exp_ovr[0]);
    rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("overrun drained", qsize(0), 0);
    chk("overrun valid drop", vld[0], 0);
    chk("overrun sticky", ovr[0], exp_ovr[0]);
    wait_bits(2);
    chk("no late frame", vld[0], 0);

    d = 8'h96;
    rx[0] = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx[0] = d[i];
      if (i < 3) wait_bits(1);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("mid-frame busy", busy[0], 1);
    rst   = 1'b0;
    rx[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-frame reset outputs",
        {dout[0], vld[0], busy[0], ferr[0], perr[0], ovr[0]}, 0);
    rst = 1'b1;
    exp_ovr[0] = 1'b0;
    exp_ovr[1] = 1'b0;
    wait_bits(2);
    chk("no partial word", vld[0], 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    drain(0);
    chk("overrun cleared", ovr[0], exp_ovr[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
